mips_multicycle_control: RTL

Multi-cycle control unit for the MIPS core: sequences fetch, decode, execute, memory and write-back around the instruction decoder, register file, ALU and a shared instruction/data memory port. It consumes the decoder's `opcode`/`func` fields plus ALU and memory status. It drives every datapath enable and mux select, one state per cycle, with stall-on-memory handshaking.

---
 rtl/mips_multicycle_control.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control unit: walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB. It drives the datapath enables and mux selects
// for the current state and stalls in FETCH/MEM until memory is ready.
module mips_multicycle_control #(
    parameter int PC_INC = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [5:0]  opcode,
    input  logic [5:0]  func,
    input  logic        alu_zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_load,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        reg_write,
    output logic [1:0]  reg_dst,
    output logic [1:0]  wb_src,
    output logic [1:0]  alu_src_b,
    output logic [3:0]  alu_op,
    output logic [2:0]  state,
    output logic        halted,
    output logic        illegal,
    output logic [31:0] instr_count
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd4;

    // The datapath holds PC_INC on this operand input; the select code
    // itself does not depend on the constant's value.
    localparam logic [1:0] SRCB_RT   = 2'd0;
    localparam logic [1:0] SRCB_PCI  = (PC_INC != 0) ? 2'd1 : 2'd1;
    localparam logic [1:0] SRCB_SEXT = 2'd2;
    localparam logic [1:0] SRCB_ZEXT = 2'd3;

    logic [2:0]  r_state;
    logic [31:0] r_instr_count;
    logic [2:0]  w_next_state;
    logic        w_count_inc;

    // Instruction classification from the decoder fields.
    logic       w_rtype, w_r_arith, w_jr, w_syscall;
    logic       w_lw, w_sw, w_beq, w_bne, w_addi, w_andi, w_ori, w_j, w_jal;
    logic       w_i_arith, w_supported, w_illegal;
    logic [3:0] w_r_aluop;

    logic       w_mem_req, w_mem_we, w_ir_load, w_pc_write, w_reg_write;
    logic [1:0] w_pc_src, w_reg_dst, w_wb_src, w_alu_src_b;
    logic [3:0] w_alu_op;

    assign w_rtype   = (opcode == 6'h00);
    assign w_jr      = w_rtype && (func == 6'h08);
    assign w_syscall = w_rtype && (func == 6'h0c);
    assign w_lw      = (opcode == 6'h23);
    assign w_sw      = (opcode == 6'h2b);
    assign w_beq     = (opcode == 6'h04);
    assign w_bne     = (opcode == 6'h05);
    assign w_addi    = (opcode == 6'h08);
    assign w_andi    = (opcode == 6'h0c);
    assign w_ori     = (opcode == 6'h0d);
    assign w_j       = (opcode == 6'h02);
    assign w_jal     = (opcode == 6'h03);
    assign w_i_arith = w_addi || w_andi || w_ori;

    // R-type arithmetic function decode to an ALU operation.
    always_comb begin
        w_r_arith = 1'b0;
        w_r_aluop = ALU_ADD;
        if (w_rtype) begin
            case (func)
                6'h20:   begin w_r_arith = 1'b1; w_r_aluop = ALU_ADD; end
                6'h22:   begin w_r_arith = 1'b1; w_r_aluop = ALU_SUB; end
                6'h24:   begin w_r_arith = 1'b1; w_r_aluop = ALU_AND; end
                6'h25:   begin w_r_arith = 1'b1; w_r_aluop = ALU_OR;  end
                6'h2a:   begin w_r_arith = 1'b1; w_r_aluop = ALU_SLT; end
                default: begin w_r_arith = 1'b0; w_r_aluop = ALU_ADD; end
            endcase
        end
    end

    assign w_supported = w_r_arith || w_jr || w_syscall || w_lw || w_sw ||
                         w_beq || w_bne || w_i_arith || w_j || w_jal;
    assign w_illegal   = (r_state == S_DECODE) && !w_supported;

    // State register and retired-instruction counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_FETCH;
            r_instr_count <= 32'd0;
        end else begin
            r_state <= w_next_state;
            if (w_count_inc)
                r_instr_count <= r_instr_count + 32'd1;
        end
    end

    // Next-state selection and the retire event.
    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH:  w_next_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (!w_supported || w_j || w_jal) w_next_state = S_FETCH;
                else if (w_syscall)               w_next_state = S_HALT;
                else                              w_next_state = S_EXEC;
            end
            S_EXEC: begin
                if (w_r_arith || w_i_arith) w_next_state = S_WB;
                else if (w_lw || w_sw)      w_next_state = S_MEM;
                else                        w_next_state = S_FETCH;
            end
            S_MEM: begin
                if (!mem_ready) w_next_state = S_MEM;
                else if (w_lw)  w_next_state = S_WB;
                else            w_next_state = S_FETCH;
            end
            S_WB:     w_next_state = S_FETCH;
            S_HALT:   w_next_state = S_HALT;
            default:  w_next_state = S_FETCH;
        endcase
        // An instruction retires when it leaves for FETCH (or HALT for
        // syscall) from any post-fetch state; skipped illegal ones do not.
        w_count_inc = (r_state == S_DECODE || r_state == S_EXEC ||
                       r_state == S_MEM    || r_state == S_WB) &&
                      (w_next_state == S_FETCH || w_next_state == S_HALT) &&
                      !w_illegal;
    end

    // Datapath controls decoded from the current state and inputs.
    always_comb begin
        w_mem_req   = 1'b0;
        w_mem_we    = 1'b0;
        w_ir_load   = 1'b0;
        w_pc_write  = 1'b0;
        w_pc_src    = 2'd0;
        w_reg_write = 1'b0;
        w_reg_dst   = 2'd0;
        w_wb_src    = 2'd0;
        w_alu_src_b = SRCB_RT;
        w_alu_op    = ALU_ADD;
        case (r_state)
            S_FETCH: begin
                w_mem_req   = 1'b1;
                w_alu_src_b = SRCB_PCI;
                w_alu_op    = ALU_ADD;
                if (mem_ready) begin
                    w_ir_load  = 1'b1;
                    w_pc_write = 1'b1;
                    w_pc_src   = 2'd0;
                end
            end
            S_DECODE: begin
                if (w_j || w_jal) begin
                    w_pc_write = 1'b1;
                    w_pc_src   = 2'd2;
                end
                if (w_jal) begin
                    w_reg_write = 1'b1;
                    w_reg_dst   = 2'd2;
                    w_wb_src    = 2'd2;
                end
            end
            S_EXEC: begin
                if (w_r_arith) begin
                    w_alu_src_b = SRCB_RT;
                    w_alu_op    = w_r_aluop;
                end else if (w_addi || w_lw || w_sw) begin
                    w_alu_src_b = SRCB_SEXT;
                    w_alu_op    = ALU_ADD;
                end else if (w_andi) begin
                    w_alu_src_b = SRCB_ZEXT;
                    w_alu_op    = ALU_AND;
                end else if (w_ori) begin
                    w_alu_src_b = SRCB_ZEXT;
                    w_alu_op    = ALU_OR;
                end else if (w_beq || w_bne) begin
                    w_alu_src_b = SRCB_RT;
                    w_alu_op    = ALU_SUB;
                    if ((w_beq && alu_zero) || (w_bne && !alu_zero)) begin
                        w_pc_write = 1'b1;
                        w_pc_src   = 2'd1;
                    end
                end else if (w_jr) begin
                    w_pc_write = 1'b1;
                    w_pc_src   = 2'd3;
                end
            end
            S_MEM: begin
                w_mem_req = 1'b1;
                w_mem_we  = w_sw;
            end
            S_WB: begin
                w_reg_write = 1'b1;
                if (w_lw) begin
                    w_reg_dst = 2'd0;
                    w_wb_src  = 2'd1;
                end else if (w_rtype) begin
                    w_reg_dst = 2'd1;
                    w_wb_src  = 2'd0;
                end else begin
                    w_reg_dst = 2'd0;
                    w_wb_src  = 2'd0;
                end
            end
            default: begin
                w_mem_req = 1'b0;
            end
        endcase
    end

    // Every output is held at zero while reset is asserted.
    assign mem_req     = reset_n & w_mem_req;
    assign mem_we      = reset_n & w_mem_we;
    assign ir_load     = reset_n & w_ir_load;
    assign pc_write    = reset_n & w_pc_write;
    assign pc_src      = reset_n ? w_pc_src    : 2'd0;
    assign reg_write   = reset_n & w_reg_write;
    assign reg_dst     = reset_n ? w_reg_dst   : 2'd0;
    assign wb_src      = reset_n ? w_wb_src    : 2'd0;
    assign alu_src_b   = reset_n ? w_alu_src_b : 2'd0;
    assign alu_op      = reset_n ? w_alu_op    : 4'd0;
    assign illegal     = reset_n & w_illegal;
    assign halted      = reset_n & (r_state == S_HALT);
    assign state       = r_state;
    assign instr_count = r_instr_count;

endmodule
